// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calc multiplier datapath.
package calc_pkg;

  localparam int RAH_PACKET_WIDTH_DFLT = 48;
  localparam int RESULT_WIDTH_DFLT     = 2 * RAH_PACKET_WIDTH_DFLT;
  localparam int STATE_W               = 3;

  typedef enum logic [STATE_W-1:0] {
    RX_IDLE     = 3'd0,
    RX_WAIT_HI  = 3'd1,
    RX_FETCH_LO = 3'd2,
    RX_WAIT_LO  = 3'd3,
    RX_HOLD     = 3'd4
  } rx_state_e;

endpackage

// File: rtl/mul_result_rx.sv
// Drains the multiplier result FIFO and rebuilds {upper, lower} products.
// Optional result_count output when MUL_RX_COUNT_EN is defined.
module mul_result_rx
  import calc_pkg::*;
#(
  parameter int RAH_PACKET_WIDTH = RAH_PACKET_WIDTH_DFLT,
  parameter int FIFO_RD_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RAH_PACKET_WIDTH-1:0]   fifo_dout,
  input  logic                          fifo_empty,
  output logic                          fifo_rden,
  output logic [2*RAH_PACKET_WIDTH-1:0] result,
  output logic                          result_valid,
  input  logic                          result_ready
`ifdef MUL_RX_COUNT_EN
  ,
  output logic [15:0]                   result_count
`endif
);

  localparam int         PW  = RAH_PACKET_WIDTH;
  localparam int         RW  = 2 * RAH_PACKET_WIDTH;
  localparam logic [1:0] LAT = 2'(FIFO_RD_LATENCY);

  rx_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [PW-1:0]     hi_q, hi_d;
  logic [RW-1:0]     res_q, res_d;
  logic              valid_q, valid_d;
  logic              rden;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    res_d   = res_q;
    valid_d = valid_q;
    rden    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!fifo_empty) begin
          rden    = 1'b1;
          cnt_d   = 2'd1;
          state_d = RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: begin
        if (cnt_q == LAT) begin
          hi_d    = fifo_dout;
          cnt_d   = 2'd0;
          state_d = RX_FETCH_LO;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RX_FETCH_LO: begin
        if (!fifo_empty) begin
          rden    = 1'b1;
          cnt_d   = 2'd1;
          state_d = RX_WAIT_LO;
        end
      end
      RX_WAIT_LO: begin
        if (cnt_q == LAT) begin
          res_d   = {hi_q, fifo_dout};
          valid_d = 1'b1;
          cnt_d   = 2'd0;
          state_d = RX_HOLD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RX_HOLD: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= 2'd0;
      hi_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  // Read strobe is decoded from state so it lands in the same cycle
  // the FIFO is seen non-empty; held low while reset is asserted.
  assign fifo_rden    = rden & rst_n;
  assign result       = res_q;
  assign result_valid = valid_q;

`ifdef MUL_RX_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valid_q && result_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign result_count = count_q;
`endif

endmodule

// File: doc/mul_result_rx.md
Name: mul_result_rx

Overview:
- Consumer at the output side of the calc multiplier path.
- Drains the result FIFO that the multiplier fills with a 96-bit product, written as two 48-bit words, upper word first.
- Reassembles each word pair into one full-width result.
- Presents the result downstream with a valid/ready handshake.
- Handles FIFO read latency and empty-FIFO stalls between the two words.

Parameters:
- RAH_PACKET_WIDTH, 48, width of one FIFO word; result width is 2*RAH_PACKET_WIDTH.
- FIFO_RD_LATENCY, 1, cycles from the rden pulse to valid fifo_dout; legal range 1..3.

Ports:
- clk  input  1  single clock, all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- fifo_dout  input  RAH_PACKET_WIDTH  result FIFO read data
- fifo_empty  input  1  result FIFO empty flag
- fifo_rden  output  1  result FIFO read enable; one-cycle pulse per word
- result  output  2*RAH_PACKET_WIDTH  reassembled product, {upper, lower}
- result_valid  output  1  result holds a complete product
- result_ready  input  1  downstream accepts result when high together with result_valid

Behaviour:
- Reset (async assert, sync-safe deassert):
  - fifo_rden=0, result_valid=0, result=0.
  - Word registers cleared, latency counter=0, state=IDLE.
- States: IDLE, WAIT_HI, FETCH_LO, WAIT_LO, HOLD.
- IDLE: if fifo_empty=0, pulse fifo_rden for exactly one cycle and go to WAIT_HI.
- WAIT_HI:
  - Count FIFO_RD_LATENCY cycles after the rden cycle.
  - On the cycle fifo_dout is valid, capture the upper word and go to FETCH_LO.
- FETCH_LO:
  - If fifo_empty=0, pulse fifo_rden and go to WAIT_LO.
  - If empty, stay with rden=0, indefinitely, without timeout.
  - The upper word is retained while waiting.
- WAIT_LO: same latency rule as WAIT_HI; capture the lower word, load result={upper, lower}, set result_valid=1, go to HOLD.
- HOLD:
  - result and result_valid are stable until result_ready=1.
  - On the handshake cycle, result_valid drops next cycle and the state returns to IDLE.
  - No FIFO read is issued in HOLD, so at most one product is outstanding.
- fifo_rden is never asserted while fifo_empty=1, and never on two consecutive cycles.
- Throughput, FIFO_RD_LATENCY=1, FIFO never empty, ready tied high:
  - One result every 5 cycles.
  - First rden to result_valid is 4 cycles.
- Word ordering is fixed: the first word read is always the upper half. No resynchronisation exists; a reset is the only realignment.
- Reset mid-operation:
  - Any partially assembled word is discarded.
  - A read already issued whose data returns after reset is ignored.
  - The next read after reset is treated as an upper word.
- fifo_empty asserting during WAIT_HI or WAIT_LO has no effect; the data of an issued read is captured regardless.

Optional Feature:
- Macro: MUL_RX_COUNT_EN.
- Defined:
  - Adds output result_count (16 bits), reset to 0.
  - Increments on each result_valid && result_ready cycle.
  - Saturates at 0xFFFF, with no wrap.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package calc_pkg:
  - RAH_PACKET_WIDTH default.
  - State encoding localparams, 3 bits, shared with the multiplier FSM style.
  - Result width constant.
- Sub-module: none required.
  - The latency counter is small enough to stay inline.
  - An optional rd_latency_tracker (rden in, data_valid out, delay FIFO_RD_LATENCY) is acceptable if reused by the operand-side reader.

Test Plan:
- Words 0x000000000001 then 0x000000000002 queued, ready=1 -> result=0x000000000001_000000000002 and result_valid for one cycle; rden pulsed exactly twice.
- Upper word 0xFFFFFFFFFFFF queued; lower word 0x123456789ABC arrives 10 cycles later -> no rden while empty; result=0xFFFFFFFFFFFF_123456789ABC.
- Result presented with ready=0 for 7 cycles -> result and valid stable; no rden pulse; accepted on the 8th cycle; IDLE next.
- rst_n pulsed low during WAIT_LO with FIFO_RD_LATENCY=2 -> outputs zero immediately; the next two words 0xA and 0xB give result=0x00000000000A_00000000000B.
- Four back-to-back products with ready=1 and FIFO_RD_LATENCY=1 -> results in order, spaced 5 cycles apart.
- MUL_RX_COUNT_EN defined, 3 accepted results -> result_count=3; preloaded to 0xFFFF, then one more accepted -> stays 0xFFFF.
